// File: rtl/pmod_pin_manager.sv
// pmod_pin_manager: AXI4-Lite GPIO block with per-pin direction, set/clear,
// synchronized inputs and edge-triggered interrupts.
module pmod_pin_manager #(
    parameter int NUM_PINS           = 8,
    parameter int SYNC_STAGES        = 2,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                    s00_axi_awprot,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                    s00_axi_arprot,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    input  logic [NUM_PINS-1:0]           pin_i,
    output logic [NUM_PINS-1:0]           pin_o,
    output logic [NUM_PINS-1:0]           pin_t,
    output logic                          irq
);
    localparam int N = NUM_PINS;

    logic                          aw_acc_q, bvalid_q, ar_acc_q, rvalid_q, irq_q;
    logic [31:0]                   rdata_q, rdata_d;
    logic [N-1:0]                  out_q, out_d, dir_q, dir_d, ien_q, ien_d;
    logic [N-1:0]                  ist_q, ist_d, edge_q, edge_d, dly_q;
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [31:0]                   wa, ra, bm;
    logic [N-1:0]                  in_s, wm, wv, hit;
    logic                          wen, unused;

    assign wa   = 32'(s00_axi_awaddr);
    assign ra   = 32'(s00_axi_araddr);
    assign bm   = {{8{s00_axi_wstrb[3]}}, {8{s00_axi_wstrb[2]}}, {8{s00_axi_wstrb[1]}}, {8{s00_axi_wstrb[0]}}};
    assign wm   = bm[N-1:0];
    assign wv   = s00_axi_wdata[N-1:0] & wm;
    // Address/data are sampled in the cycle awready is high, when the master must still hold them.
    assign wen  = aw_acc_q && wa[31:5] == 27'd0;
    assign in_s = sync_q[SYNC_STAGES-1];
    assign hit  = (edge_q & in_s & ~dly_q) | (~edge_q & ~in_s & dly_q);

    assign s00_axi_awready = aw_acc_q;
    assign s00_axi_wready  = aw_acc_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = ar_acc_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign pin_o           = out_q;
    assign pin_t           = ~dir_q;
    assign irq             = irq_q;
    assign unused          = ^{s00_axi_awprot, s00_axi_arprot, wa, ra, bm, s00_axi_wdata};

    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        ien_d   = ien_q;
        ist_d   = ist_q;
        edge_d  = edge_q;
        rdata_d = 32'd0;
        if (wen) begin
            case (wa[4:2])
                3'd0:    out_d  = (out_q & ~wm) | wv;
                3'd1:    dir_d  = (dir_q & ~wm) | wv;
                3'd3:    out_d  = out_q | wv;
                3'd4:    out_d  = out_q & ~wv;
                3'd5:    ien_d  = (ien_q & ~wm) | wv;
                3'd6:    ist_d  = ist_q & ~wv;
                3'd7:    edge_d = (edge_q & ~wm) | wv;
                default: ;
            endcase
        end
        // Applied after the W1C so a same-cycle hardware event wins.
        ist_d = ist_d | hit;
        if (ra[31:5] == 27'd0) begin
            case (ra[4:2])
                3'd0:    rdata_d = 32'(out_q);
                3'd1:    rdata_d = 32'(dir_q);
                3'd2:    rdata_d = 32'(in_s);
                3'd5:    rdata_d = 32'(ien_q);
                3'd6:    rdata_d = 32'(ist_q);
                3'd7:    rdata_d = 32'(edge_q);
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_acc_q <= 1'b0;
            bvalid_q <= 1'b0;
            ar_acc_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
            out_q    <= '0;
            dir_q    <= '0;
            ien_q    <= '0;
            ist_q    <= '0;
            edge_q   <= '0;
            dly_q    <= '0;
            sync_q   <= '0;
        end else begin
            aw_acc_q <= s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~aw_acc_q;
            bvalid_q <= aw_acc_q | (bvalid_q & ~s00_axi_bready);
            ar_acc_q <= s00_axi_arvalid & ~rvalid_q & ~ar_acc_q;
            rvalid_q <= ar_acc_q | (rvalid_q & ~s00_axi_rready);
            if (ar_acc_q) rdata_q <= rdata_d;
            irq_q    <= |(ist_q & ien_q);
            out_q    <= out_d;
            dir_q    <= dir_d;
            ien_q    <= ien_d;
            ist_q    <= ist_d;
            edge_q   <= edge_d;
            dly_q    <= in_s;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end
endmodule

// File: tb/tb_pmod_pin_manager.sv
// tb_pmod_pin_manager: directed checks of the AXI register map, handshakes,
// synchronizer timing, edge interrupts and asynchronous reset.
module tb_pmod_pin_manager;
    localparam int NP = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [NP-1:0] pin_i = '0, pin_o, pin_t;
    int            total = 0, bad = 0;
    logic [31:0]   rd;
    logic [1:0]    rs, ws;

    always #5 clk = ~clk;

    pmod_pin_manager #(.NUM_PINS(NP), .SYNC_STAGES(2), .C_S_AXI_ADDR_WIDTH(AW)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .pin_i(pin_i), .pin_o(pin_o), .pin_t(pin_t), .irq(irq)
    );

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit ok = 0;
        resp = 2'bxx;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = awready;
        end
        if (!ok) begin total++; bad++; $display("FAIL wr_accept_timeout addr=%h", a); end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; resp = bresp; end
        end
        if (!ok) begin total++; bad++; $display("FAIL wr_bvalid_timeout addr=%h", a); end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ok = 0;
        d = 'x; resp = 2'bxx;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) begin total++; bad++; $display("FAIL rd_accept_timeout addr=%h", a); end
        @(posedge clk); #1;
        arvalid = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1; d = rdata; resp = rresp; end
        end
        if (!ok) begin total++; bad++; $display("FAIL rd_rvalid_timeout addr=%h", a); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (pin_t !== 8'hFF) begin bad++; $display("FAIL rst_pin_t_in_reset got=%h exp=ff", pin_t); end
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        total++; if (pin_o !== 8'h00) begin bad++; $display("FAIL rst_pin_o got=%h exp=00", pin_o); end
        total++; if (pin_t !== 8'hFF) begin bad++; $display("FAIL rst_pin_t got=%h exp=ff", pin_t); end
        total++; if ({irq, awready, wready, bvalid, arready, rvalid} !== 6'b0)
            begin bad++; $display("FAIL rst_ctrl got=%b exp=000000", {irq, awready, wready, bvalid, arready, rvalid}); end
        axi_read(6'h00, rd, rs);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_out_rd got=%h exp=0", rd); end
    endtask

    task automatic test_out_dir();
        axi_write(6'h00, 32'h0000_00A5, 4'hF, ws);
        total++; if (ws !== 2'b00) begin bad++; $display("FAIL out_bresp got=%b exp=00", ws); end
        axi_write(6'h04, 32'h0000_000F, 4'hF, ws);
        total++; if (pin_o !== 8'hA5) begin bad++; $display("FAIL out_pin_o got=%h exp=a5", pin_o); end
        total++; if (pin_t !== 8'hF0) begin bad++; $display("FAIL dir_pin_t got=%h exp=f0", pin_t); end
        axi_read(6'h00, rd, rs);
        total++; if (rd !== 32'hA5) begin bad++; $display("FAIL out_rd got=%h exp=a5", rd); end
        total++; if (rs !== 2'b00) begin bad++; $display("FAIL out_rresp got=%b exp=00", rs); end
        axi_read(6'h04, rd, rs);
        total++; if (rd !== 32'h0F) begin bad++; $display("FAIL dir_rd got=%h exp=0f", rd); end
    endtask

    task automatic test_set_clr();
        axi_write(6'h0C, 32'h02, 4'hF, ws);
        total++; if (pin_o !== 8'hA7) begin bad++; $display("FAIL set_pin_o got=%h exp=a7", pin_o); end
        axi_write(6'h10, 32'h81, 4'hF, ws);
        axi_read(6'h00, rd, rs);
        total++; if (rd !== 32'h26) begin bad++; $display("FAIL setclr_out got=%h exp=26", rd); end
        axi_read(6'h0C, rd, rs);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL set_rd got=%h exp=0", rd); end
        axi_read(6'h10, rd, rs);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL clr_rd got=%h exp=0", rd); end
    endtask

    task automatic test_irq();
        axi_write(6'h1C, 32'h01, 4'hF, ws);
        axi_write(6'h14, 32'h01, 4'hF, ws);
        @(negedge clk);
        pin_i[0] = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
        axi_read(6'h08, rd, rs);
        total++; if (rd !== 32'h01) begin bad++; $display("FAIL in_rd got=%h exp=01", rd); end
        axi_read(6'h18, rd, rs);
        total++; if (rd !== 32'h01) begin bad++; $display("FAIL stat_rd got=%h exp=01", rd); end
        axi_write(6'h18, 32'h01, 4'hF, ws);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b exp=0", irq); end
        // falling edge on bit0 is ignored; falling edge on bit1 is flagged but not enabled
        @(negedge clk); pin_i[0] = 0; pin_i[1] = 1;
        repeat (5) @(negedge clk);
        pin_i[1] = 0;
        repeat (5) @(negedge clk);
        axi_read(6'h18, rd, rs);
        total++; if (rd !== 32'h02) begin bad++; $display("FAIL stat_fall got=%h exp=02", rd); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq); end
        axi_write(6'h18, 32'h02, 4'hF, ws);
        axi_read(6'h18, rd, rs);
        total++; if (rd !== 32'h00) begin bad++; $display("FAIL stat_clr got=%h exp=00", rd); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        awaddr = 6'h00; wdata = 32'h11; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (awready !== 1'b0) begin bad++; $display("FAIL b2b_early_accept cyc=%0d got=%b exp=0", i, awready); end
        end
        wvalid = 1;
        @(negedge clk);
        total++; if ({awready, wready} !== 2'b11) begin bad++; $display("FAIL b2b_accept got=%b exp=11", {awready, wready}); end
        @(posedge clk); #1;
        wdata = 32'h33;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ({bvalid, awready} !== 2'b10) begin bad++; $display("FAIL b2b_hold cyc=%0d got=%b exp=10", i, {bvalid, awready}); end
        end
        total++; if (pin_o !== 8'h11) begin bad++; $display("FAIL b2b_first got=%h exp=11", pin_o); end
        bready = 1;
        @(negedge clk);
        total++; if ({bvalid, awready} !== 2'b00) begin bad++; $display("FAIL b2b_gap got=%b exp=00", {bvalid, awready}); end
        @(negedge clk);
        total++; if (awready !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b exp=1", awready); end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL b2b_bvalid2 got=%b exp=1", bvalid); end
        @(posedge clk); #1;
        axi_read(6'h00, rd, rs);
        total++; if (rd !== 32'h33) begin bad++; $display("FAIL b2b_out got=%h exp=33", rd); end
    endtask

    task automatic test_strobes();
        axi_write(6'h00, 32'hFFFF_FFFF, 4'h1, ws);
        axi_read(6'h00, rd, rs);
        total++; if (rd !== 32'hFF) begin bad++; $display("FAIL strb_out got=%h exp=ff", rd); end
        axi_write(6'h00, 32'h0, 4'h2, ws);
        axi_read(6'h00, rd, rs);
        total++; if (rd !== 32'hFF) begin bad++; $display("FAIL strb_masked got=%h exp=ff", rd); end
        axi_write(6'h20, 32'h0, 4'hF, ws);
        total++; if (ws !== 2'b00) begin bad++; $display("FAIL unmap_bresp got=%b exp=00", ws); end
        axi_read(6'h20, rd, rs);
        total++; if (rd !== 32'h0 || rs !== 2'b00) begin bad++; $display("FAIL unmap_rd got=%h/%b exp=0/00", rd, rs); end
        axi_read(6'h00, rd, rs);
        total++; if (rd !== 32'hFF) begin bad++; $display("FAIL unmap_wr_leak got=%h exp=ff", rd); end
    endtask

    task automatic test_same_reg_rw();
        @(negedge clk);
        awaddr = 6'h00; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        araddr = 6'h00; arvalid = 1; rready = 1;
        @(negedge clk);
        total++; if ({awready, arready} !== 2'b11) begin bad++; $display("FAIL rw_accept got=%b exp=11", {awready, arready}); end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        total++; if (rvalid !== 1'b1 || rdata !== 32'hFF) begin bad++; $display("FAIL rw_old got=%b/%h exp=1/ff", rvalid, rdata); end
        @(posedge clk); #1;
        axi_read(6'h00, rd, rs);
        total++; if (rd !== 32'h5A) begin bad++; $display("FAIL rw_new got=%h exp=5a", rd); end
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        @(negedge clk); pin_i[0] = 1;
        repeat (6) @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_irq_pre got=%b exp=1", irq); end
        araddr = 6'h00; arvalid = 1; rready = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rvalid;
            if (arready) arvalid = 0;
        end
        arvalid = 0;
        repeat (2) @(negedge clk);
        total++; if (!ok || rvalid !== 1'b1) begin bad++; $display("FAIL mid_rvalid_hold got=%b exp=1", rvalid); end
        #2 rst_n = 0;
        #1;
        total++; if ({rvalid, irq} !== 2'b00) begin bad++; $display("FAIL mid_async_ctrl got=%b exp=00", {rvalid, irq}); end
        total++; if (pin_o !== 8'h00 || pin_t !== 8'hFF) begin bad++; $display("FAIL mid_async_pins got=%h/%h exp=00/ff", pin_o, pin_t); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata got=%h exp=0", rdata); end
        pin_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        rready = 1;
        for (int a = 0; a < 8; a++) begin
            axi_read(AW'(a * 4), rd, rs);
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_reg_rd off=%h got=%h exp=0", a * 4, rd); end
        end
    endtask

    initial begin
        test_reset();
        test_out_dir();
        test_set_clr();
        test_irq();
        test_back_to_back();
        test_strobes();
        test_same_reg_rw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pmod_pin_manager.md
PMOD_PIN_MANAGER -- requirements
Module: pmod_pin_manager

Interface
REQ-001 SHALL have parameter NUM_PINS, default 8: number of managed pins, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..4.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5: AXI4-Lite byte address width; data width is fixed at 32.
REQ-004 s00_axi_aclk  in  1  single clock; all state changes on its rising edge.
REQ-005 s00_axi_aresetn  in  1  asynchronous, active-low reset.
REQ-006 s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
REQ-007 s00_axi_awprot  in  3  ignored.
REQ-008 s00_axi_awvalid  in  1  write address valid.
REQ-009 s00_axi_awready  out  1  write address ready.
REQ-010 s00_axi_wdata  in  32  write data.
REQ-011 s00_axi_wstrb  in  4  byte write strobes.
REQ-012 s00_axi_wvalid  in  1  write data valid.
REQ-013 s00_axi_wready  out  1  write data ready.
REQ-014 s00_axi_bresp  out  2  write response, always OKAY (00).
REQ-015 s00_axi_bvalid  out  1  write response valid.
REQ-016 s00_axi_bready  in  1  write response ready.
REQ-017 s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
REQ-018 s00_axi_arprot  in  3  ignored.
REQ-019 s00_axi_arvalid  in  1  read address valid.
REQ-020 s00_axi_arready  out  1  read address ready.
REQ-021 s00_axi_rdata  out  32  read data.
REQ-022 s00_axi_rresp  out  2  read response, always OKAY (00).
REQ-023 s00_axi_rvalid  out  1  read data valid.
REQ-024 s00_axi_rready  in  1  read data ready.
REQ-025 pin_i  in  NUM_PINS  asynchronous pad inputs.
REQ-026 pin_o  out  NUM_PINS  pad output values.
REQ-027 pin_t  out  NUM_PINS  tristate enables (1 = pad is input), equal to ~DIR.
REQ-028 irq  out  1  registered level interrupt.

Function
REQ-029 Register map (word offsets): 0x00 OUT RW; 0x04 DIR RW (1 = output); 0x08 IN RO; 0x0C SET WO; 0x10 CLR WO; 0x14 IRQ_EN RW; 0x18 IRQ_STAT RW1C; 0x1C IRQ_EDGE RW (1 = rising, 0 = falling).
REQ-030 Write accept: awready and wready pulse high together for exactly one cycle when awvalid and wvalid are both high, bvalid is low, and no accept occurred in the previous cycle.
REQ-031 bvalid SHALL rise the cycle after accept and hold until bready is sampled high; no new write is accepted while bvalid is high.
REQ-032 Read accept: arready pulses for one cycle when arvalid is high and rvalid is low; rvalid and rdata are registered the next cycle, with rdata held stable until rready is sampled high.
REQ-033 wstrb SHALL be honoured per byte on RW registers and on SET, CLR and IRQ_STAT; bytes with a cleared strobe are unaffected.
REQ-034 SET: OUT |= wdata; CLR: OUT &= ~wdata; reads of SET and CLR return 0.
REQ-035 Bits at or above NUM_PINS SHALL read 0 and ignore writes; unmapped offsets read 0 and ignore writes, still returning OKAY.
REQ-036 pin_o = OUT for all bits regardless of DIR; IN returns the synchronized pin_i for all pins, including output pins.
REQ-037 IN bit n SHALL reflect a stable pin_i[n] change exactly SYNC_STAGES cycles after the first sampling edge.
REQ-038 Edge detect: compare the synchronized value with a one-cycle-delayed copy; a change matching IRQ_EDGE[n] sets IRQ_STAT[n] on the next edge; input pins and output pins both detect edges.
REQ-039 If a hardware set and a W1C of the same IRQ_STAT bit occur in the same cycle, the set SHALL win.
REQ-040 irq SHALL be registered: high the cycle after |(IRQ_STAT & IRQ_EN) is 1, low the cycle after it is 0.
REQ-041 Simultaneous read and write to the same register: the read returns the value before the write.

Reset
REQ-042 When aresetn is low, all registers, synchronizer and delay flops, awready, wready, bvalid, arready, rvalid, rdata, pin_o and irq SHALL be 0, and pin_t SHALL be all 1 (all pins input); release takes effect on the first clock edge with aresetn high, including mid-transaction (any outstanding transfer is dropped).

Verification
REQ-043 Write 0x000000A5 to OUT and 0x0F to DIR, then read both -> pin_o = 0xA5, pin_t = 0xF0, reads return 0xA5 and 0x0F, bresp and rresp = 00.
REQ-044 With OUT = 0xA5: write 0x02 to SET, then 0x81 to CLR -> OUT reads 0x26; SET and CLR read 0.
REQ-045 IRQ_EDGE = 0x01, IRQ_EN = 0x01; drive pin_i[0] 0->1 -> IN[0] = 1 after 2 cycles, IRQ_STAT = 0x01, irq = 1; write 0x01 to IRQ_STAT -> irq = 0 the cycle after.
REQ-046 Assert awvalid 3 cycles before wvalid and hold bready low for 4 cycles -> single accept pulse only after both are valid, bvalid held 4 cycles, and a second queued write is not accepted until bvalid falls.
REQ-047 Write 0xFFFFFFFF to OUT with wstrb = 0x1 at NUM_PINS = 8, and read offset 0x1C+4 wrapped/unmapped -> OUT = 0xFF, upper bits read 0, unmapped read 0 with OKAY.
REQ-048 Assert aresetn low while rvalid is high with rready low -> rvalid, irq and pin_o clear immediately (asynchronously), pin_t = 0xFF, and all registers read reset values after release.
